// File: rtl/io_port_bridge.sv
// io_port_bridge: device-side responder for the CPU four-phase I/O handshake.
// Host words enter through the input FIFO, and the CPU pops them with io_read.
// The CPU pushes words into the output FIFO with io_write, and the host drains them.
// Each handshake performs exactly one FIFO operation and then waits for the
// request to be released before going back to IDLE.
module io_port_bridge #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_read,
  input  logic                  io_write,
  input  logic [WIDTH-1:0]      io_wdata,
  output logic [WIDTH-1:0]      io_rdata,
  output logic                  ioack,
  input  logic                  in_valid,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   in_count,
  output logic [DEPTH_LOG2:0]   out_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];

  typedef enum logic {IDLE, ACK} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]      inMem_q  [DEPTH];
  logic [WIDTH-1:0]      outMem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] inWrPtr_q, inRdPtr_q, outWrPtr_q, outRdPtr_q;
  logic [DEPTH_LOG2:0]   inCount_q, outCount_q;
  logic [WIDTH-1:0]      rdata_q;

  logic inFull, inEmpty, outFull, outEmpty;
  logic hostPush, hostPop, cpuPush, cpuPop;

  assign inFull   = (inCount_q == FULL_COUNT);
  assign inEmpty  = (inCount_q == '0);
  assign outFull  = (outCount_q == FULL_COUNT);
  assign outEmpty = (outCount_q == '0);

  // The host-side handshakes are gated only by FIFO occupancy, so they never
  // overwrite a full FIFO or underflow an empty one.
  assign hostPush = in_valid & ~inFull;
  assign hostPop  = out_ready & ~outEmpty;

  assign in_ready  = ~inFull;
  assign out_valid = ~outEmpty;
  assign out_data  = outMem_q[outRdPtr_q];
  assign in_count  = inCount_q;
  assign out_count = outCount_q;
  assign io_rdata  = rdata_q;
  assign ioack     = (state_q == ACK);

  // State register for the CPU handshake sequencer.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state: leave IDLE only when a transfer can be served.
  // Return to IDLE only after both requests are released.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cpuPush || cpuPop) state_d = ACK;
      ACK:  if (!io_read && !io_write) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO strobes: a write has priority over a read, and only IDLE ever
  // issues an operation, which gives exactly one operation per handshake.
  always_comb begin
    cpuPush = 1'b0;
    cpuPop  = 1'b0;
    if (state_q == IDLE) begin
      if (io_write && !outFull)     cpuPush = 1'b1;
      else if (io_read && !inEmpty) cpuPop  = 1'b1;
    end
  end

  // Input FIFO pointers and occupancy.
  // A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      inWrPtr_q <= '0;
      inRdPtr_q <= '0;
      inCount_q <= '0;
    end else begin
      if (hostPush) inWrPtr_q <= inWrPtr_q + 1'b1;
      if (cpuPop)   inRdPtr_q <= inRdPtr_q + 1'b1;
      unique case ({hostPush, cpuPop})
        2'b10:   inCount_q <= inCount_q + 1'b1;
        2'b01:   inCount_q <= inCount_q - 1'b1;
        default: inCount_q <= inCount_q;
      endcase
    end
  end

  // Output FIFO pointers and occupancy.
  // The CPU pushes into this FIFO, and the host pops from it.
  always_ff @(posedge clock) begin
    if (reset) begin
      outWrPtr_q <= '0;
      outRdPtr_q <= '0;
      outCount_q <= '0;
    end else begin
      if (cpuPush) outWrPtr_q <= outWrPtr_q + 1'b1;
      if (hostPop) outRdPtr_q <= outRdPtr_q + 1'b1;
      unique case ({cpuPush, hostPop})
        2'b10:   outCount_q <= outCount_q + 1'b1;
        2'b01:   outCount_q <= outCount_q - 1'b1;
        default: outCount_q <= outCount_q;
      endcase
    end
  end

  // FIFO storage. Reset clears only the pointers; stale words become unreachable.
  always_ff @(posedge clock) begin
    if (hostPush) inMem_q[inWrPtr_q]   <= in_data;
    if (cpuPush)  outMem_q[outWrPtr_q] <= io_wdata;
  end

  // Read data register: loaded on a CPU pop and held at all other times.
  always_ff @(posedge clock) begin
    if (reset)       rdata_q <= '0;
    else if (cpuPop) rdata_q <= inMem_q[inRdPtr_q];
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// tb_io_port_bridge: directed plus randomized checks of io_port_bridge.
// The reference model uses two queues and an "acknowledged" flag.
module tb_io_port_bridge;

  localparam int WIDTH = 16;
  localparam int DL    = 3;
  localparam int DEPTH = 8;

  logic             clock = 1'b0;
  logic             reset, io_read, io_write, in_valid, out_ready;
  logic [WIDTH-1:0] io_wdata, in_data;
  logic [WIDTH-1:0] io_rdata, out_data;
  logic             ioack, in_ready, out_valid;
  logic [DL:0]      in_count, out_count;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [WIDTH-1:0] inQ[$];
  logic [WIDTH-1:0] outQ[$];
  bit               mAck;
  logic [WIDTH-1:0] mRdata;

  io_port_bridge #(.WIDTH(WIDTH), .DEPTH_LOG2(DL)) dut (
    .clock(clock), .reset(reset), .io_read(io_read), .io_write(io_write),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .ioack(ioack),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .in_count(in_count), .out_count(out_count)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance the model by one clock edge, using the inputs applied at that edge.
  task automatic modelEdge();
    int  inSz  = inQ.size();
    int  outSz = outQ.size();
    bit  hPush = in_valid && (inSz < DEPTH);
    bit  hPop  = out_ready && (outSz > 0);
    if (reset) begin
      inQ.delete();
      outQ.delete();
      mAck   = 1'b0;
      mRdata = '0;
    end else begin
      if (hPop) void'(outQ.pop_front());
      if (!mAck) begin
        if (io_write && outSz < DEPTH) begin
          outQ.push_back(io_wdata);
          mAck = 1'b1;
        end else if (io_read && inSz > 0) begin
          mRdata = inQ.pop_front();
          mAck   = 1'b1;
        end
      end else if (!io_read && !io_write) begin
        mAck = 1'b0;
      end
      if (hPush) inQ.push_back(in_data);
    end
  endtask

  task automatic checkAll(string tag);
    checkOutput({tag, ".ioack"},     32'(ioack),     32'(mAck));
    checkOutput({tag, ".io_rdata"},  32'(io_rdata),  32'(mRdata));
    checkOutput({tag, ".in_count"},  32'(in_count),  32'(inQ.size()));
    checkOutput({tag, ".out_count"}, 32'(out_count), 32'(outQ.size()));
    checkOutput({tag, ".in_ready"},  32'(in_ready),  32'(inQ.size() < DEPTH));
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(outQ.size() > 0));
    if (outQ.size() > 0)
      checkOutput({tag, ".out_data"}, 32'(out_data), 32'(outQ[0]));
  endtask

  task automatic applyStimulus(string tag);
    modelEdge();
    @(posedge clock);
    #1;
    checkAll(tag);
  endtask

  initial begin
    int sent;
    int recv;
    reset = 1'b1; io_read = 1'b0; io_write = 1'b0; io_wdata = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    mAck = 1'b0; mRdata = '0;
    #2;

    // Reset.
    applyStimulus("reset0");
    applyStimulus("reset1");
    reset = 1'b0;
    applyStimulus("postReset");
    checkOutput("rst.ioack",     32'(ioack),     32'd0);
    checkOutput("rst.in_ready",  32'(in_ready),  32'd1);
    checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst.in_count",  32'(in_count),  32'd0);
    checkOutput("rst.out_count", 32'(out_count), 32'd0);
    checkOutput("rst.io_rdata",  32'(io_rdata),  32'd0);

    // Basic reads.
    in_valid = 1'b1; in_data = 16'h1234; applyStimulus("rd.push1");
    in_data = 16'hBEEF;                  applyStimulus("rd.push2");
    in_valid = 1'b0; io_read = 1'b1;     applyStimulus("rd.req1");
    checkOutput("rd.ack1",   32'(ioack),    32'd1);
    checkOutput("rd.data1",  32'(io_rdata), 32'h1234);
    io_read = 1'b0;                      applyStimulus("rd.rel1");
    checkOutput("rd.rel1ack", 32'(ioack),   32'd0);
    io_read = 1'b1;                      applyStimulus("rd.req2");
    checkOutput("rd.data2",  32'(io_rdata), 32'hBEEF);
    checkOutput("rd.cnt2",   32'(in_count), 32'd0);
    io_read = 1'b0;                      applyStimulus("rd.rel2");

    // Write until full, then stall.
    out_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      io_write = 1'b1; io_wdata = 16'(k); applyStimulus("wr.req");
      checkOutput("wr.ack", 32'(ioack), 32'd1);
      io_write = 1'b0;                    applyStimulus("wr.rel");
    end
    checkOutput("wr.full.count", 32'(out_count), 32'd8);
    checkOutput("wr.full.valid", 32'(out_valid), 32'd1);
    checkOutput("wr.full.head",  32'(out_data),  32'h0001);
    io_write = 1'b1; io_wdata = 16'h0009;
    for (int k = 0; k < 3; k++) begin
      applyStimulus("wr.stall");
      checkOutput("wr.stall.ack", 32'(ioack), 32'd0);
    end
    out_ready = 1'b1; applyStimulus("wr.pop");
    checkOutput("wr.pop.ack", 32'(ioack), 32'd0);
    out_ready = 1'b0; applyStimulus("wr.unstall");
    checkOutput("wr.unstall.ack",   32'(ioack),     32'd1);
    checkOutput("wr.unstall.count", 32'(out_count), 32'd8);
    io_write = 1'b0; applyStimulus("wr.rel9");
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) applyStimulus("wr.drain");
    checkOutput("wr.drained", 32'(out_count), 32'd0);
    out_ready = 1'b0;

    // Read stall on an empty FIFO.
    io_read = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus("rs.stall");
      checkOutput("rs.stall.ack", 32'(ioack), 32'd0);
    end
    in_valid = 1'b1; in_data = 16'h00AA; applyStimulus("rs.push");
    in_valid = 1'b0;                     applyStimulus("rs.ack");
    checkOutput("rs.ack.ack",  32'(ioack),    32'd1);
    checkOutput("rs.ack.data", 32'(io_rdata), 32'h00AA);
    for (int k = 0; k < 4; k++) begin
      applyStimulus("rs.hold");
      checkOutput("rs.hold.cnt", 32'(in_count), 32'd0);
    end
    io_read = 1'b0; applyStimulus("rs.rel");

    // Streaming with simultaneous host pushes and CPU reads.
    sent = 0; recv = 0;
    for (int c = 0; c < 300 && recv < 20; c++) begin
      bit acc;
      in_valid = (sent < 20);
      in_data  = 16'(16'h0100 + sent);
      if (io_read && mAck) io_read = 1'b0;
      else if (!io_read && !mAck) io_read = 1'b1;
      acc = in_valid && (inQ.size() < DEPTH);
      applyStimulus("wrap");
      if (acc) sent++;
      checkOutput("wrap.bound", 32'(in_count <= 4'd8), 32'd1);
      if (io_read && mAck) begin
        checkOutput("wrap.order", 32'(io_rdata), 32'(16'h0100 + recv));
        recv++;
      end
    end
    checkOutput("wrap.recv", 32'(recv), 32'd20);
    in_valid = 1'b0; io_read = 1'b0; applyStimulus("wrap.rel");

    // Reset in the middle of a handshake.
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 16'(16'h0200 + k); applyStimulus("mr.push");
    end
    in_valid = 1'b0; io_read = 1'b1; applyStimulus("mr.req");
    checkOutput("mr.ack",   32'(ioack),    32'd1);
    checkOutput("mr.count", 32'(in_count), 32'd3);
    reset = 1'b1; applyStimulus("mr.reset");
    checkOutput("mr.reset.ack",  32'(ioack),     32'd0);
    checkOutput("mr.reset.cin",  32'(in_count),  32'd0);
    checkOutput("mr.reset.cout", 32'(out_count), 32'd0);
    reset = 1'b0; io_read = 1'b0; applyStimulus("mr.after");
    checkOutput("mr.after.ready", 32'(in_ready), 32'd1);

    // Randomized traffic checked against the model.
    for (int c = 0; c < 600; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      reset     = ($urandom_range(0, 99) == 0);
      if ((io_read || io_write) && mAck) begin
        if ($urandom_range(0, 1) == 1) begin
          io_read = 1'b0; io_write = 1'b0;
        end
      end else if (!io_read && !io_write && !mAck && $urandom_range(0, 1) == 1) begin
        if ($urandom_range(0, 1) == 1) io_read = 1'b1;
        else begin
          io_write = 1'b1;
          io_wdata = 16'($urandom);
        end
      end
      applyStimulus("rand");
    end
    reset = 1'b0; io_read = 1'b0; io_write = 1'b0; in_valid = 1'b0;
    applyStimulus("rand.end");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
